// File: rtl/password_pkg.sv
// Shared definitions for the keypad collector and the downstream password checker.
package password_pkg;

    localparam int unsigned PW_WIDTH_DEFAULT = 4;
    localparam int unsigned PW_COUNT_W       = $clog2(PW_WIDTH_DEFAULT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        READY  = 2'd2,
        LOCKED = 2'd3
    } collector_state_t;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, counter debouncer and registered one-cycle press pulse.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]       sync;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Pulse is raised on the same edge the debounced level rises.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= 2'b00;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                press <= sync[1];
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_entry_collector.sv
// Debounces keypad buttons and assembles an MSB-first password for the checker.
module keypad_entry_collector
    import password_pkg::*;
#(
    parameter int unsigned PW_WIDTH        = PW_WIDTH_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned IDLE_TIMEOUT    = 1000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              btn_zero,
    input  logic                              btn_one,
    input  logic                              btn_submit,
    input  logic                              btn_clear,
    input  logic                              locked,
    output logic [PW_WIDTH-1:0]               password,
    output logic                              enter,
    output logic [$clog2(PW_WIDTH+1)-1:0]     digit_count,
    output logic                              entry_error
);

    localparam int unsigned CNT_W = $clog2(PW_WIDTH + 1);
    localparam int unsigned TMR_W = $clog2(IDLE_TIMEOUT + 1);

    logic zero_press, one_press, submit_press, clear_press;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_zero (
        .clk(clk), .reset(reset), .btn(btn_zero), .press(zero_press));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_one (
        .clk(clk), .reset(reset), .btn(btn_one), .press(one_press));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_submit (
        .clk(clk), .reset(reset), .btn(btn_submit), .press(submit_press));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk(clk), .reset(reset), .btn(btn_clear), .press(clear_press));

    collector_state_t  state, state_n;
    logic [PW_WIDTH-1:0] sr, sr_n;
    logic [CNT_W-1:0]    cnt_n;
    logic [TMR_W-1:0]    timer, timer_n;
    logic [PW_WIDTH-1:0] password_n;
    logic                enter_n;
    logic                error_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sr          <= '0;
            digit_count <= '0;
            timer       <= '0;
            password    <= '0;
            enter       <= 1'b0;
            entry_error <= 1'b0;
        end else begin
            state       <= state_n;
            sr          <= sr_n;
            digit_count <= cnt_n;
            timer       <= timer_n;
            password    <= password_n;
            enter       <= enter_n;
            entry_error <= error_n;
        end
    end

    // Priority: locked > clear > submit > digit > idle timer.
    always_comb begin
        state_n    = state;
        sr_n       = sr;
        cnt_n      = digit_count;
        timer_n    = timer;
        password_n = '0;
        enter_n    = 1'b0;
        error_n    = 1'b0;

        if (locked) begin
            state_n = LOCKED;
            sr_n    = '0;
            cnt_n   = '0;
            timer_n = '0;
        end else if (state == LOCKED) begin
            state_n = IDLE;
        end else if (clear_press) begin
            state_n = IDLE;
            sr_n    = '0;
            cnt_n   = '0;
            timer_n = '0;
        end else if (submit_press) begin
            if (digit_count == CNT_W'(PW_WIDTH)) begin
                enter_n    = 1'b1;
                password_n = sr;
            end else begin
                error_n = 1'b1;
            end
            state_n = IDLE;
            sr_n    = '0;
            cnt_n   = '0;
            timer_n = '0;
        end else if ((zero_press ^ one_press) && (state != READY)) begin
            sr_n    = PW_WIDTH'({sr, one_press});
            cnt_n   = digit_count + CNT_W'(1);
            timer_n = '0;
            state_n = (cnt_n == CNT_W'(PW_WIDTH)) ? READY : ENTRY;
        end else if ((state == ENTRY) || (state == READY)) begin
            if (timer == TMR_W'(IDLE_TIMEOUT - 1)) begin
                state_n = IDLE;
                sr_n    = '0;
                cnt_n   = '0;
                timer_n = '0;
            end else begin
                timer_n = timer + TMR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry_collector.sv
// Directed bench for keypad_entry_collector with short debounce and idle timeout.
module tb_keypad_entry_collector;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_zero, btn_one, btn_submit, btn_clear, locked;
    logic [3:0] password;
    logic       enter;
    logic [2:0] digit_count;
    logic       entry_error;

    int checks = 0;
    int fails  = 0;

    int         enter_cycles = 0;
    int         err_cycles   = 0;
    int         pw_leak      = 0;
    logic [3:0] last_pw      = 4'h0;

    keypad_entry_collector #(
        .PW_WIDTH(4), .DEBOUNCE_CYCLES(4), .IDLE_TIMEOUT(50)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_zero(btn_zero), .btn_one(btn_one),
        .btn_submit(btn_submit), .btn_clear(btn_clear),
        .locked(locked),
        .password(password), .enter(enter),
        .digit_count(digit_count), .entry_error(entry_error)
    );

    always #5 clk = ~clk;

    // Observe strobes away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (enter) begin
                enter_cycles++;
                last_pw = password;
            end
            if (entry_error) err_cycles++;
            if (!enter && password != 4'h0) pw_leak++;
        end
    end

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: btn_zero   = v;
            1: btn_one    = v;
            2: btn_submit = v;
            default: btn_clear = v;
        endcase
    endtask

    task automatic press(input int which);
        set_btn(which, 1'b1);
        repeat (8) @(negedge clk);
        set_btn(which, 1'b0);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; btn_zero = 0; btn_one = 0; btn_submit = 0; btn_clear = 0; locked = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({password, enter, digit_count, entry_error} !== 9'd0) begin
            $display("FAIL reset_outputs: got pw=%b en=%b cnt=%0d err=%b expected all 0",
                     password, enter, digit_count, entry_error);
            fails++;
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean_entry;
        int bits[4] = '{1, 0, 1, 1};
        int lat = 0;
        int e0  = enter_cycles;
        int r0  = err_cycles;
        for (int i = 0; i < 4; i++) begin
            press(bits[i]);
            checks++;
            if (digit_count !== 3'(i + 1)) begin
                $display("FAIL t1_count_%0d: got %0d expected %0d", i, digit_count, i + 1);
                fails++;
            end
        end
        // Measure raw-submit to enter latency in rising edges.
        btn_submit = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (enter && lat == 0) lat = k;
        end
        btn_submit = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (lat !== 7) begin
            $display("FAIL t1_latency: got %0d expected 7", lat); fails++;
        end
        checks++;
        if (enter_cycles - e0 !== 1) begin
            $display("FAIL t1_enter_cycles: got %0d expected 1", enter_cycles - e0); fails++;
        end
        checks++;
        if (last_pw !== 4'b1011) begin
            $display("FAIL t1_password: got %b expected 1011", last_pw); fails++;
        end
        checks++;
        if (digit_count !== 3'd0 || err_cycles != r0) begin
            $display("FAIL t1_after: got cnt=%0d errs=%0d expected cnt=0 errs=0",
                     digit_count, err_cycles - r0);
            fails++;
        end
    endtask

    task automatic test_bounce;
        btn_one = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            btn_one = ~btn_one;
        end
        btn_one = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (digit_count !== 3'd0) begin
            $display("FAIL t2_bounce: got %0d expected 0", digit_count); fails++;
        end
        press(1);
        checks++;
        if (digit_count !== 3'd1) begin
            $display("FAIL t2_held: got %0d expected 1", digit_count); fails++;
        end
        press(3);
        checks++;
        if (digit_count !== 3'd0) begin
            $display("FAIL t2_clear: got %0d expected 0", digit_count); fails++;
        end
    endtask

    task automatic test_short_submit;
        int e0 = enter_cycles;
        int r0 = err_cycles;
        press(1); press(0); press(2);
        checks++;
        if (err_cycles - r0 !== 1) begin
            $display("FAIL t3_error_cycles: got %0d expected 1", err_cycles - r0); fails++;
        end
        checks++;
        if (enter_cycles != e0 || digit_count !== 3'd0) begin
            $display("FAIL t3_no_enter: got enters=%0d cnt=%0d expected 0 0",
                     enter_cycles - e0, digit_count);
            fails++;
        end
    endtask

    task automatic test_overflow;
        int bits[5] = '{1, 1, 0, 0, 1};
        int e0 = enter_cycles;
        for (int i = 0; i < 5; i++) press(bits[i]);
        checks++;
        if (digit_count !== 3'd4) begin
            $display("FAIL t4_saturate: got %0d expected 4", digit_count); fails++;
        end
        press(2);
        checks++;
        if (enter_cycles - e0 !== 1 || last_pw !== 4'b1100) begin
            $display("FAIL t4_password: got enters=%0d pw=%b expected 1 1100",
                     enter_cycles - e0, last_pw);
            fails++;
        end
    endtask

    task automatic test_lock;
        int bits[4] = '{1, 0, 1, 1};
        int e0 = enter_cycles;
        int r0 = err_cycles;
        press(1); press(1);
        locked = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (digit_count !== 3'd0) begin
            $display("FAIL t5_lock_clear: got %0d expected 0", digit_count); fails++;
        end
        press(0); press(2);
        checks++;
        if (digit_count !== 3'd0 || enter_cycles != e0 || err_cycles != r0) begin
            $display("FAIL t5_lock_ignore: got cnt=%0d enters=%0d errs=%0d expected 0 0 0",
                     digit_count, enter_cycles - e0, err_cycles - r0);
            fails++;
        end
        locked = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) press(bits[i]);
        press(2);
        checks++;
        if (enter_cycles - e0 !== 1 || last_pw !== 4'b1011) begin
            $display("FAIL t5_unlock_entry: got enters=%0d pw=%b expected 1 1011",
                     enter_cycles - e0, last_pw);
            fails++;
        end
    endtask

    task automatic test_timeout_clear_reset;
        int e0 = enter_cycles;
        int r0 = err_cycles;
        press(1); press(0); press(1);
        checks++;
        if (digit_count !== 3'd3) begin
            $display("FAIL t6_before_timeout: got %0d expected 3", digit_count); fails++;
        end
        repeat (50) @(negedge clk);
        checks++;
        if (digit_count !== 3'd0 || enter_cycles != e0 || err_cycles != r0) begin
            $display("FAIL t6_timeout: got cnt=%0d enters=%0d errs=%0d expected 0 0 0",
                     digit_count, enter_cycles - e0, err_cycles - r0);
            fails++;
        end
        press(1); press(1); press(0); press(0);
        btn_clear = 1'b1; btn_submit = 1'b1;
        repeat (8) @(negedge clk);
        btn_clear = 1'b0; btn_submit = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (digit_count !== 3'd0 || enter_cycles != e0 || err_cycles != r0) begin
            $display("FAIL t6_clear_wins: got cnt=%0d enters=%0d errs=%0d expected 0 0 0",
                     digit_count, enter_cycles - e0, err_cycles - r0);
            fails++;
        end
        press(1); press(0);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({password, enter, digit_count, entry_error} !== 9'd0) begin
            $display("FAIL t6_mid_reset: got pw=%b en=%b cnt=%0d err=%b expected all 0",
                     password, enter, digit_count, entry_error);
            fails++;
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_clean_entry();
        test_bounce();
        test_short_submit();
        test_overflow();
        test_lock();
        test_timeout_clear_reset();
        checks++;
        if (pw_leak !== 0) begin
            $display("FAIL password_zero_when_idle: got %0d nonzero cycles expected 0", pw_leak);
            fails++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
